// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg: state encoding and counter sizing for the serial adder
package serial_add_ctrl_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  function automatic int cnt_w(input int w);
    return w > 1 ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/fa.sv
// fa: gate-level full adder cell
module fa (
  output logic sum,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin
);
  logic p, g, t;
  xor (p, a, b);
  xor (sum, p, cin);
  and (g, a, b);
  and (t, p, cin);
  or  (cout, g, t);
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer sharing one full-adder cell
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = cnt_w(WIDTH);
  logic [1:0] state;
  logic [WIDTH-1:0] ra, rb;
  logic [CW-1:0] cnt;
  logic c, s, co, last;
  logic [WIDTH:0] sh;
  fa u_fa (.sum(s), .cout(co), .a(ra[0]), .b(rb[0]), .cin(c));
  assign busy = state == RUN;
  assign done = state == DONE;
  assign last = cnt == CW'(WIDTH - 1);
  assign sh   = {s, sum} >> 1;
  // sequencing: load on start, shift one bit pair per RUN cycle, pulse DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        ra    <= a;
        rb    <= b;
        c     <= cin;
        cnt   <= '0;
        state <= RUN;
      end
    end else if (state == RUN) begin
      sum   <= sh[WIDTH-1:0];
      c     <= co;
      ra    <= ra >> 1;
      rb    <= rb >> 1;
      cnt   <= cnt + 1'b1;
      cout  <= last ? co : cout;
      state <= last ? DONE : RUN;
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed self-checking bench for serial_add_ctrl
module tb_serial_add_ctrl;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic busy, done, cout;
  logic [7:0] sum;
  int errors = 0, checks = 0, per = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    per++;
  endtask

  task automatic launch(input logic [7:0] va, input logic [7:0] vb, input logic vc);
    tick();
    a = va; b = vb; cin = vc; start = 1'b1;
    per = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int bc);
    bc = 0;
    while (!done && per < 30) begin
      if (busy) bc++;
      tick();
    end
  endtask

  logic [7:0] ta [5] = '{8'h00, 8'hFF, 8'h7F, 8'hA5, 8'h12};
  logic [7:0] tb [5] = '{8'h00, 8'h01, 8'h01, 8'h5A, 8'h34};
  logic       tc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [7:0] ts [5] = '{8'h00, 8'h00, 8'h80, 8'h00, 8'h47};
  logic       to [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    int bc, nd, lastp;
    logic [7:0] hs;
    logic hc;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);

    for (int i = 0; i < 5; i++) begin
      launch(ta[i], tb[i], tc[i]);
      wait_done(bc);
      chk("lat", per, 9);
      chk("busy_cycles", bc, 8);
      chk("sum", sum, ts[i]);
      chk("cout", cout, to[i]);
      chk("busy_in_done", busy, 0);
      tick();
      chk("done_pulse", done, 0);
    end

    launch(8'h03, 8'h04, 1'b0);
    tick(); tick();
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(bc);
    chk("ign_lat", per, 9);
    chk("ign_sum", sum, 8'h07);
    chk("ign_cout", cout, 0);
    nd = 0;
    repeat (15) begin tick(); if (done) nd++; end
    chk("ign_one_done", nd, 0);

    launch(8'hF0, 8'h0F, 1'b0);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_sum", sum, 0);
    chk("mrst_cout", cout, 0);
    nd = 0;
    repeat (15) begin tick(); if (done) nd++; end
    chk("mrst_no_done", nd, 0);
    launch(8'h01, 8'h01, 1'b0);
    wait_done(bc);
    chk("mrst_after_sum", sum, 8'h02);
    chk("mrst_after_lat", per, 9);

    tick();
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    nd = 0; lastp = -1;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (done) begin
        nd++;
        chk("b2b_sum", sum, 8'h30);
        chk("b2b_busy_done", busy, 0);
        if (lastp >= 0) chk("b2b_interval", i - lastp, 10);
        lastp = i;
        tick();
        i++;
        chk("b2b_busy_idle", busy, 0);
      end
    end
    chk("b2b_count", nd >= 4, 1);
    start = 1'b0;
    repeat (12) tick();

    launch(8'hC3, 8'h3C, 1'b1);
    wait_done(bc);
    chk("hold_sum0", sum, 8'h00);
    chk("hold_cout0", cout, 1);
    hs = sum; hc = cout;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      if (done || sum !== 8'h00 || cout !== 1'b1) nd++;
    end
    chk("hold_stable", nd, 0);
    chk("hold_sum", sum, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
